// File: rtl/dmadd_sequencer.sv
// Host-side sequencer for the DMADD engine: reset, init, load beats, timed run, result capture.
// Optional macro DMADD_EARLY_DONE_EN ends the run window early once eng_out has settled.
module dmadd_sequencer #(
    parameter int RUN_CYCLES    = 18,
    parameter int STABLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_index,
    input  logic [3:0]  cmd_data,
    input  logic        cmd_last,
    output logic        eng_rst_n,
    output logic [1:0]  eng_insn,
    output logic [3:0]  eng_index,
    output logic [3:0]  eng_data,
    output logic        eng_load,
    output logic        eng_run,
    input  logic [11:0] eng_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_data,
    output logic        res_err
);

    // state  | meaning
    // IDLE   | waiting for the first beat of a job; latches op
    // CLEAR  | engine held in reset for one cycle
    // INIT   | one quiet cycle after engine reset
    // LOAD   | accepting beats, one load pulse per accepted beat
    // DRAIN  | last load pulse completes, run armed
    // RUN    | eng_run high for the run window
    // SETTLE | one quiet cycle, then eng_out captured
    // DONE   | result held until the consumer takes it

    localparam int CNT_W = $clog2(RUN_CYCLES + 1);

    if (RUN_CYCLES < 1 || STABLE_CYCLES < 2) begin : g_bad_params
        $error("dmadd_sequencer: RUN_CYCLES must be >= 1 and STABLE_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        IDLE, CLEAR, INIT, LOAD, DRAIN, RUN, SETTLE, DONE
    } state_t;

    state_t             state, state_nxt;
    logic               err_q;
    logic [CNT_W-1:0]   run_cnt;
    logic               beat_acc;
    logic               run_done;

    assign cmd_ready = (state == LOAD);
    assign beat_acc  = cmd_valid & cmd_ready;

`ifdef DMADD_EARLY_DONE_EN
    localparam int STAB_W = $clog2(STABLE_CYCLES);

    logic [11:0]       prev_out;
    logic              prev_vld;
    logic [STAB_W-1:0] stab_cnt;
    logic              same;
    logic              stable_hit;

    // stab_cnt counts matching pairs, so STABLE_CYCLES samples need STABLE_CYCLES-1 matches
    assign same       = prev_vld && (eng_out == prev_out);
    assign stable_hit = same && (stab_cnt == STAB_W'(STABLE_CYCLES - 2));
    assign run_done   = (run_cnt == '0) || stable_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_out <= '0;
            prev_vld <= 1'b0;
            stab_cnt <= '0;
        end else if (state != RUN) begin
            prev_vld <= 1'b0;
            stab_cnt <= '0;
        end else begin
            prev_out <= eng_out;
            prev_vld <= 1'b1;
            stab_cnt <= same ? stab_cnt + 1'b1 : '0;
        end
    end
`else
    assign run_done = (run_cnt == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = CLEAR;
            CLEAR:   state_nxt = INIT;
            INIT:    state_nxt = LOAD;
            LOAD:    if (beat_acc && cmd_last) state_nxt = DRAIN;
            DRAIN:   state_nxt = RUN;
            RUN:     if (run_done) state_nxt = SETTLE;
            SETTLE:  state_nxt = DONE;
            DONE:    if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // eng_insn doubles as the latched job op; it must stay put until the result is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_rst_n <= 1'b0;
            eng_insn  <= 2'b00;
            eng_index <= 4'h0;
            eng_data  <= 4'h0;
            eng_load  <= 1'b0;
            eng_run   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 12'h000;
            res_err   <= 1'b0;
            err_q     <= 1'b0;
            run_cnt   <= '0;
        end else begin
            eng_rst_n <= (state_nxt != CLEAR);
            eng_run   <= (state_nxt == RUN);
            eng_load  <= beat_acc;

            if (beat_acc) begin
                eng_index <= cmd_index;
                eng_data  <= cmd_data;
                if (cmd_op != eng_insn) err_q <= 1'b1;
            end

            if (state == IDLE && cmd_valid) begin
                eng_insn <= cmd_op;
                err_q    <= (cmd_op == 2'b11);
            end

            if (state == DRAIN)
                run_cnt <= CNT_W'(RUN_CYCLES - 1);
            else if (state == RUN && run_cnt != '0)
                run_cnt <= run_cnt - 1'b1;

            if (state == SETTLE) begin
                res_data  <= eng_out;
                res_err   <= err_q;
                res_valid <= 1'b1;
            end else if (state == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dmadd_sequencer.md
Name: dmadd_sequencer

Overview:
- Host-side initiator that drives the DMADD engine's load/run interface.
- Accepts a job as a stream of (op, index, data) beats on a valid/ready handshake.
- For each job it resets the engine, holds one init cycle, issues one load pulse per beat, runs the engine for a bounded window, then captures the 12-bit engine result into a valid/ready result port.
- Sits between the command front-end and the DMADD engine.

Parameters:
- RUN_CYCLES, 18: cycles eng_run is held high; covers a full 16-entry sweep plus margin. Minimum 1.
- STABLE_CYCLES, 3: used only with DMADD_EARLY_DONE_EN. Number of consecutive unchanged eng_out samples that ends RUN early. Minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command beat valid
- cmd_ready  out  1  command beat accepted when valid&ready at posedge
- cmd_op  in  2  00 MIN, 01 MAX, 10 MADD, 11 illegal
- cmd_index  in  4  engine memory index
- cmd_data  in  4  operand (MADD only)
- cmd_last  in  1  final beat of job
- eng_rst_n  out  1  engine reset, active-low
- eng_insn  out  2  engine instruction
- eng_index  out  4  engine index
- eng_data  out  4  engine data
- eng_load  out  1  engine load strobe
- eng_run  out  1  engine run enable
- eng_out  in  12  engine result
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when valid&ready
- res_data  out  12  captured eng_out
- res_err  out  1  job had an illegal or mismatched op

Behaviour:
- All eng_* and res_* outputs are registered. cmd_ready is combinational from state.
- Reset values: state IDLE, eng_rst_n=0, eng_insn=00, eng_index=0, eng_data=0, eng_load=0, eng_run=0, res_valid=0, res_data=0, res_err=0, cmd_ready=0.
- rst asserted in any state aborts the job immediately. No result is produced and no partially accepted beat is retained.
- IDLE:
  - eng_rst_n=1, load=0, run=0, cmd_ready=0.
  - When cmd_valid=1, latch op=cmd_op and clear the err flag. The beat is not consumed. Go to CLEAR.
  - If cmd_op==11, set err.
- CLEAR: eng_rst_n=0 for exactly 1 cycle; eng_insn=op. Go to INIT.
- INIT: eng_rst_n=1, load=0, run=0 for exactly 1 cycle. Go to LOAD.
- LOAD:
  - cmd_ready=1.
  - Each accepted beat drives eng_load=1, eng_index=cmd_index, eng_data=cmd_data in the following cycle.
  - With no accepted beat, eng_load=0 next cycle and index/data hold their values.
  - A beat whose cmd_op differs from the latched op sets err; it is still loaded, using the latched op on eng_insn.
  - Accepting a beat with cmd_last=1 moves to DRAIN.
  - cmd_valid low stalls indefinitely.
- DRAIN: cmd_ready=0 for 1 cycle so the last load pulse completes. eng_run is registered high on the transition to RUN, so eng_run rises the cycle after the last eng_load.
- RUN:
  - eng_run=1 for exactly RUN_CYCLES cycles, counted by a $clog2(RUN_CYCLES+1)-bit down-counter.
  - Then eng_run=0 and go to SETTLE.
- SETTLE: 1 cycle with run=0. At its end, res_data<=eng_out, res_err<=err, res_valid<=1. Go to DONE.
- DONE:
  - res_valid=1 and res_data held until res_valid&res_ready; then res_valid=0 and go to IDLE.
  - cmd_ready=0.
  - eng_insn holds op throughout, because eng_out depends on insn.
- Illegal op (11): the full sequence still executes, with eng_insn=11 and res_err=1.
- Back-to-back jobs: a new cmd_valid seen in IDLE the cycle after the DONE handshake starts CLEAR with no extra gap.
- Single-beat job: cmd_last on the first beat gives exactly one load pulse.
- Job latency, N beats with no stalls: CLEAR(1) + INIT(1) + N + DRAIN(1) + RUN_CYCLES + SETTLE(1) cycles from leaving IDLE to res_valid.

Optional Feature:
- Macro: DMADD_EARLY_DONE_EN.
- Defined:
  - RUN also ends when eng_out has been identical for STABLE_CYCLES consecutive samples while run=1.
  - RUN_CYCLES remains the upper bound.
  - Adds a 12-bit previous-value register and a stability counter.
- Undefined: fixed RUN_CYCLES window only; eng_out is sampled only in SETTLE.

Test Plan:
- Reset mid-RUN (rst for 1 cycle at RUN cycle 5) -> next cycle eng_run=0, eng_rst_n=0, res_valid=0, state IDLE. A following job completes normally.
- MADD job, beats (idx 4, data 3), (idx 7, data 2, last), no stalls -> eng_rst_n low 1 cycle, eng_insn=10; eng_load high 2 consecutive cycles with index/data 4/3 then 7/2; eng_run high exactly 18 cycles starting 2 cycles after the first load; res_data equals the bench engine model's eng_out; res_err=0.
- MIN job, beat idx 5 last, with cmd_valid dropped 3 cycles before it -> eng_load stays 0 during the stall, then one pulse with index 5; res_err=0.
- Op mismatch: first beat op=01, second beat op=10 -> eng_insn stays 01 throughout; res_err=1.
- res_ready held low 10 cycles -> res_valid and res_data stable and cmd_ready=0 for all 10 cycles; IDLE entered the cycle after the handshake.
- With DMADD_EARLY_DONE_EN, STABLE_CYCLES=3, engine model freezing eng_out=0x005 from run cycle 4 -> eng_run falls after run cycle 6; res_data=0x005.
